rr_select_arbiter: RTL and testbench



---
 rtl/rr_select_arbiter_pkg.sv | 13 +
 rtl/rr_select_arbiter_if.sv | 22 ++
 rtl/rr_select_arbiter_pick.sv | 29 ++
 rtl/rr_select_arbiter.sv | 91 +++++++++
 tb/tb_rr_select_arbiter.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/rr_select_arbiter_pkg.sv
// Shared types and constants for the round-robin select arbiter and its decoder stage.
package rr_select_arbiter_pkg;

   localparam int unsigned NUM_REQ = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StGrant = 2'd1,
      StGap   = 2'd2
   } state_e;

endpackage

// File: rtl/rr_select_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
interface rr_select_arbiter_if;
   import rr_select_arbiter_pkg::*;

   logic [NUM_REQ-1:0] req;
   logic               done;
   logic [SEL_W-1:0]   sel;
   logic               sel_valid;
   logic               busy;
   logic               timeout;

   modport slave (
      input  req, done,
      output sel, sel_valid, busy, timeout
   );

   modport master (
      output req, done,
      input  sel, sel_valid, busy, timeout
   );

endinterface

// File: rtl/rr_select_arbiter_pick.sv
// Combinational rotating-priority pick: first asserted request at or after ptr_i (mod 4).
module rr_pick4
   import rr_select_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic [SEL_W-1:0]   winner_o,
   output logic               any_o
);

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   logic [SEL_W-1:0]     offset;

   // Doubling the vector turns the mod-4 rotation into a plain slice.
   assign req_dbl = {req_i, req_i};
   assign req_rot = req_dbl[ptr_i +: NUM_REQ];

   always_comb begin
      offset = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_rot[k]) offset = SEL_W'(k);
      end
   end

   assign winner_o = ptr_i + offset;
   assign any_o    = |req_i;

endmodule

// File: rtl/rr_select_arbiter.sv
// Four-way round-robin arbiter with hold-limit timeout and a dead cycle between grants.
module rr_select_arbiter
   import rr_select_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rr_select_arbiter_if.slave   arb_io
);

   state_e             state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sel_valid_q, sel_valid_d;
   logic               busy_q, busy_d;
   logic               timeout_q, timeout_d;

   logic [SEL_W-1:0]   winner;
   logic               any_req;
   logic               rel_normal;
   logic               hold_hit;

   rr_pick4 u_pick (
      .req_i    (arb_io.req),
      .ptr_i    (ptr_q),
      .winner_o (winner),
      .any_o    (any_req)
   );

   assign rel_normal = arb_io.done || !arb_io.req[sel_q];
   assign hold_hit   = (cnt_q == CNT_W'(MAX_HOLD - 1));

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (any_req) begin
               state_d = StGrant;
               sel_d   = winner;
               cnt_d   = '0;
            end
         end
         StGrant: begin
            cnt_d = cnt_q + 1'b1;
            if (rel_normal || hold_hit) begin
               state_d   = StGap;
               ptr_d     = sel_q + 2'd1;
               // Timeout flags only a forced release, never one the owner asked for.
               timeout_d = !rel_normal;
            end
         end
         StGap:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
      sel_valid_d = (state_d == StGrant);
      busy_d      = (state_d == StGrant) || (state_d == StGap);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         ptr_q       <= '0;
         sel_q       <= '0;
         cnt_q       <= '0;
         sel_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         sel_q       <= sel_d;
         cnt_q       <= cnt_d;
         sel_valid_q <= sel_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
      end
   end

   assign arb_io.sel       = sel_q;
   assign arb_io.sel_valid = sel_valid_q;
   assign arb_io.busy      = busy_q;
   assign arb_io.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Bench for rr_select_arbiter: directed scenarios plus random traffic against a reference model.
module tb_rr_select_arbiter;

   localparam int unsigned MaxHold = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   rr_select_arbiter_if arb_if ();

   rr_select_arbiter #(
      .MAX_HOLD (MaxHold),
      .CNT_W    (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .arb_io (arb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: who owns the resource, for how long, and whose turn is next.
   int   m_phase;   // 0 free, 1 owned, 2 dead cycle
   int   m_ptr;
   int   m_owner;
   int   m_age;
   logic m_to;

   task automatic model_reset();
      m_phase = 0; m_ptr = 0; m_owner = 0; m_age = 0; m_to = 1'b0;
   endtask

   task automatic model_step(input logic [3:0] r, input logic d);
      bit user_rel;
      m_to = 1'b0;
      if (m_phase == 0) begin
         for (int k = 0; k < 4; k++) begin
            if (r[(m_ptr + k) % 4]) begin
               m_owner = (m_ptr + k) % 4;
               m_phase = 1;
               m_age   = 1;
               break;
            end
         end
      end else if (m_phase == 1) begin
         user_rel = d || !r[m_owner];
         if (user_rel || m_age == MaxHold) begin
            m_phase = 2;
            m_ptr   = (m_owner + 1) % 4;
            m_to    = !user_rel;
         end else begin
            m_age++;
         end
      end else begin
         m_phase = 0;
      end
   endtask

   function automatic logic [4:0] obs();
      return {arb_if.sel, arb_if.sel_valid, arb_if.busy, arb_if.timeout};
   endfunction

   function automatic logic [4:0] model_exp();
      return {2'(m_owner), m_phase == 1, m_phase != 0, m_to};
   endfunction

   task automatic tick(input logic [3:0] r, input logic d);
      arb_if.req  = r;
      arb_if.done = d;
      @(posedge clk);
      model_step(r, d);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; arb_if.req = '0; arb_if.done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 5'b0) begin
         errors++;
         $display("FAIL reset: got {sel,v,b,t}=%b expected %b", obs(), 5'b0);
      end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_single();
      logic [4:0] exp_v [4];
      logic [3:0] r_v   [4];
      logic       d_v   [4];
      exp_v = '{{2'd2, 3'b110}, {2'd2, 3'b010}, {2'd2, 3'b000}, {2'd3, 3'b110}};
      r_v   = '{4'b0100, 4'b0100, 4'b0000, 4'b1111};
      d_v   = '{1'b0, 1'b1, 1'b0, 1'b0};
      test_reset();
      for (int i = 0; i < 4; i++) begin
         tick(r_v[i], d_v[i]);
         checks++;
         if (obs() !== exp_v[i]) begin
            errors++;
            $display("FAIL single step%0d: got %b expected %b", i, obs(), exp_v[i]);
         end
      end
   endtask

   task automatic test_fairness();
      logic [4:0] e;
      test_reset();
      for (int g = 0; g < 5; g++) begin
         for (int c = 0; c < 4; c++) begin
            tick(4'b1111, c == 2);
            e = {2'(g % 4), c < 2, c < 3, 1'b0};
            checks++;
            if (obs() !== e) begin
               errors++;
               $display("FAIL fairness g%0d c%0d: got %b expected %b", g, c, obs(), e);
            end
         end
      end
   endtask

   task automatic test_timeout();
      logic [4:0] e;
      test_reset();
      for (int i = 0; i < 7; i++) begin
         tick(4'b0010, 1'b0);
         e = (i < 4) ? {2'd1, 3'b110} : (i == 4) ? {2'd1, 3'b011} :
             (i == 5) ? {2'd1, 3'b000} : {2'd1, 3'b110};
         checks++;
         if (obs() !== e) begin
            errors++;
            $display("FAIL timeout step%0d: got %b expected %b", i, obs(), e);
         end
      end
      tick(4'b0000, 1'b0);
      tick(4'b0000, 1'b0);
   endtask

   task automatic test_done_at_limit();
      test_reset();
      repeat (4) tick(4'b0010, 1'b0);
      tick(4'b0010, 1'b1);
      checks++;
      if (obs() !== {2'd1, 3'b010}) begin
         errors++;
         $display("FAIL done_at_limit: got %b expected %b", obs(), {2'd1, 3'b010});
      end
      tick(4'b0000, 1'b0);
   endtask

   task automatic test_withdraw();
      logic [4:0] exp_v [5];
      logic [3:0] r_v   [5];
      exp_v = '{{2'd0, 3'b110}, {2'd0, 3'b110}, {2'd0, 3'b010}, {2'd0, 3'b000}, {2'd3, 3'b110}};
      r_v   = '{4'b0001, 4'b1001, 4'b1000, 4'b1000, 4'b1000};
      test_reset();
      for (int i = 0; i < 5; i++) begin
         tick(r_v[i], 1'b0);
         checks++;
         if (obs() !== exp_v[i]) begin
            errors++;
            $display("FAIL withdraw step%0d: got %b expected %b", i, obs(), exp_v[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      test_reset();
      tick(4'b0100, 1'b0);
      checks++;
      if (obs() !== {2'd2, 3'b110}) begin
         errors++;
         $display("FAIL async_pre: got %b expected %b", obs(), {2'd2, 3'b110});
      end
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (obs() !== 5'b0) begin
         errors++;
         $display("FAIL async_drop: got %b expected %b", obs(), 5'b0);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      model_reset();
      tick(4'b1100, 1'b0);
      checks++;
      if (obs() !== {2'd2, 3'b110}) begin
         errors++;
         $display("FAIL async_regrant: got %b expected %b", obs(), {2'd2, 3'b110});
      end
   endtask

   task automatic test_random();
      logic [3:0] r;
      logic       d;
      test_reset();
      r = 4'($urandom_range(0, 15));
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
         d = ($urandom_range(0, 5) == 0);
         tick(r, d);
         checks++;
         if (obs() !== model_exp()) begin
            errors++;
            $display("FAIL random c%0d req=%b done=%b: got %b expected %b",
                     c, r, d, obs(), model_exp());
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_done_at_limit();
      test_withdraw();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
